// File: rtl/sseg_pkg.sv
// sseg_pkg: shared digit count default, nibble width and scan state encoding for the seven-segment scan driver
package sseg_pkg;
  localparam int N_DIGITS_DEF = 8;
  localparam int HEX_W = 4;
  typedef enum logic {ST_BLANK, ST_DISPLAY} state_t;
endpackage

// File: rtl/sseg_frame_buf.sv
// sseg_frame_buf: pending/active frame registers; clk, reset_n, upd_* handshake in, swap at frame boundary, act_* and nxt_hex out
module sseg_frame_buf
  import sseg_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        upd_valid,
  output logic                        upd_ready,
  input  logic [HEX_W*N_DIGITS-1:0]   upd_hex,
  input  logic [N_DIGITS-1:0]         upd_dp,
  input  logic [N_DIGITS-1:0]         upd_en,
  input  logic                        swap,
  output logic [HEX_W*N_DIGITS-1:0]   act_hex,
  output logic [N_DIGITS-1:0]         act_dp,
  output logic [N_DIGITS-1:0]         act_en,
  output logic [HEX_W*N_DIGITS-1:0]   nxt_hex
);
  logic [HEX_W*N_DIGITS-1:0] pend_hex;
  logic [N_DIGITS-1:0]       pend_dp;
  logic [N_DIGITS-1:0]       pend_en;
  always_ff @(posedge clk)
    if (!reset_n) begin
      upd_ready <= 1'b1;
      pend_hex  <= '0;
      pend_dp   <= '0;
      pend_en   <= '0;
      act_hex   <= '0;
      act_dp    <= '0;
      act_en    <= '0;
    end else begin
      if (swap && !upd_ready) begin
        act_hex <= pend_hex;
        act_dp  <= pend_dp;
        act_en  <= pend_en;
      end
      if (upd_valid && upd_ready) begin
        pend_hex  <= upd_hex;
        pend_dp   <= upd_dp;
        pend_en   <= upd_en;
        upd_ready <= 1'b0;
      end else if (swap) upd_ready <= 1'b1;
    end
  assign nxt_hex = (swap && !upd_ready) ? pend_hex : act_hex;
endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: blanked digit scan; clk, reset_n, upd_valid/upd_ready/upd_hex/upd_dp/upd_en frame in, AN/hex/DP/frame_done out
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int N_DIGITS  = N_DIGITS_DEF,
  parameter int ON_CYC    = 100000,
  parameter int BLANK_CYC = 500
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        upd_valid,
  output logic                        upd_ready,
  input  logic [HEX_W*N_DIGITS-1:0]   upd_hex,
  input  logic [N_DIGITS-1:0]         upd_dp,
  input  logic [N_DIGITS-1:0]         upd_en,
  output logic [N_DIGITS-1:0]         AN,
  output logic [HEX_W-1:0]            hex,
  output logic                        DP,
  output logic                        frame_done
);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int CNT_W = $clog2((ON_CYC > BLANK_CYC ? ON_CYC : BLANK_CYC) + 1);
  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic [IDX_W-1:0]          idx_n;
  logic [CNT_W-1:0]          cnt;
  logic                      blank_done;
  logic                      on_done;
  logic                      wrap;
  logic [HEX_W*N_DIGITS-1:0] act_hex;
  logic [HEX_W*N_DIGITS-1:0] nxt_hex;
  logic [N_DIGITS-1:0]       act_dp;
  logic [N_DIGITS-1:0]       act_en;
  assign blank_done = state == ST_BLANK && cnt == CNT_W'(BLANK_CYC - 1);
  assign on_done    = state == ST_DISPLAY && cnt == CNT_W'(ON_CYC - 1);
  assign wrap       = on_done && idx == IDX_W'(N_DIGITS - 1);
  assign idx_n      = wrap ? '0 : idx + IDX_W'(1);
  sseg_frame_buf #(.N_DIGITS(N_DIGITS)) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_hex   (upd_hex),
    .upd_dp    (upd_dp),
    .upd_en    (upd_en),
    .swap      (wrap),
    .act_hex   (act_hex),
    .act_dp    (act_dp),
    .act_en    (act_en),
    .nxt_hex   (nxt_hex)
  );
  // hex moves to the next digit at the start of its blanking gap so the decoder settles while dark
  always_ff @(posedge clk)
    if (!reset_n) begin
      state      <= ST_BLANK;
      idx        <= '0;
      cnt        <= '0;
      AN         <= '1;
      DP         <= 1'b1;
      hex        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (blank_done) begin
        state <= ST_DISPLAY;
        cnt   <= '0;
        AN    <= ~(N_DIGITS'(act_en[idx]) << idx);
        DP    <= ~act_dp[idx];
      end else if (on_done) begin
        state <= ST_BLANK;
        cnt   <= '0;
        idx   <= idx_n;
        AN    <= '1;
        DP    <= 1'b1;
        hex   <= nxt_hex[HEX_W*idx_n +: HEX_W];
      end else cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: directed checks of scan timing, handshake, frame swap and reset with ON_CYC=4, BLANK_CYC=2
module tb_sseg_scan_driver;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [31:0] upd_hex = '0;
  logic [7:0]  upd_dp = '0;
  logic [7:0]  upd_en = '0;
  logic [7:0]  AN;
  logic [3:0]  hex;
  logic        DP;
  logic        frame_done;
  int          vec_cnt = 0;
  int          err_cnt = 0;
  always #5 clk = ~clk;
  sseg_scan_driver #(.N_DIGITS(8), .ON_CYC(4), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_hex    (upd_hex),
    .upd_dp     (upd_dp),
    .upd_en     (upd_en),
    .AN         (AN),
    .hex        (hex),
    .DP         (DP),
    .frame_done (frame_done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // advance to the next falling edge; the source drops valid once a transfer has happened
  task automatic step();
    logic fire;
    fire = upd_valid && upd_ready && reset_n;
    @(negedge clk);
    if (fire) upd_valid = 1'b0;
    check("an_onehot", 32'($countones(~AN) <= 1), 32'd1);
  endtask
  task automatic offer(input logic [31:0] h, input logic [7:0] d, input logic [7:0] e);
    upd_hex   = h;
    upd_dp    = d;
    upd_en    = e;
    upd_valid = 1'b1;
  endtask
  task automatic check_reset();
    check("rst_an", AN, 32'hFF);
    check("rst_dp", DP, 32'd1);
    check("rst_hex", hex, 32'd0);
    check("rst_ready", upd_ready, 32'd1);
    check("rst_fd", frame_done, 32'd0);
  endtask
  // first frame after reset: empty active frame, boundary pulse after exactly 48 cycles
  task automatic boot(input logic rdy1);
    for (int k = 1; k <= 48; k++) begin
      step();
      if (k == 1) check("boot_ready", upd_ready, rdy1);
      check("boot_an", AN, 32'hFF);
      check("boot_hex", hex, 32'd0);
      check("boot_fd", frame_done, k == 48);
    end
  endtask
  // call on the cycle frame_done is high; returns on the next frame's first cycle
  task automatic check_frame(input string name, input logic [31:0] h, input logic [7:0] d, input logic [7:0] e);
    for (int c = 0; c < 48; c++) begin
      int s;
      int p;
      logic [7:0] ea;
      logic [7:0] one;
      logic       dpe;
      s   = c / 6;
      p   = c % 6;
      one = 8'(e[s]) << s;
      ea  = p < 2 ? 8'hFF : ~one;
      dpe = p < 2 ? 1'b1 : ~d[s];
      check({name, "_fd"}, frame_done, c == 0);
      check({name, "_an"}, AN, ea);
      check({name, "_hex"}, hex, h[4*s +: 4]);
      check({name, "_dp"}, DP, dpe);
      step();
    end
  endtask
  initial begin
    int  n;
    logic rdy;
    step();
    check_reset();
    step();
    step();
    offer(32'h76543210, 8'h01, 8'hFF);
    reset_n = 1'b1;
    boot(1'b0);
    check("swap_ready", upd_ready, 32'd1);
    check_frame("A", 32'h76543210, 8'h01, 8'hFF);
    offer(32'h89ABCDEF, 8'h80, 8'hAA);
    step();
    check("acc_B", upd_ready, 32'd0);
    offer(32'hFEDCBA98, 8'hF0, 8'h3C);
    n   = 0;
    rdy = 1'b0;
    while (!frame_done && n < 100) begin
      rdy |= upd_ready;
      step();
      n++;
    end
    check("stall_len", n, 32'd47);
    check("stall_rdy", rdy, 32'd0);
    check("B_ready", upd_ready, 32'd1);
    check_frame("B", 32'h89ABCDEF, 8'h80, 8'hAA);
    for (int f = 0; f < 3; f++) check_frame("C", 32'hFEDCBA98, 8'hF0, 8'h3C);
    repeat (20) step();
    offer(32'hA5A5A5A5, 8'hFF, 8'hFF);
    step();
    check("acc_D", upd_ready, 32'd0);
    reset_n = 1'b0;
    step();
    check_reset();
    step();
    step();
    reset_n = 1'b1;
    boot(1'b1);
    check_frame("E", 32'h0, 8'h00, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
